// File: rtl/shift_reg_32_checker_if.sv
// rtl/shift_reg_32_checker_if.sv - tap and status bundle between the register under test and its checker
//   enb/dir/s_in/modo/d : stimulus as driven to the register
//   q                   : register output being checked
//   armed/err/err_sticky/chk_cnt/err_cnt/first_exp/first_got : checker status
//   master = stimulus/bench side, slave = checker side
interface shift_reg_32_checker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [1:0]       modo;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  logic             armed;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_got;

  modport master (
    output enb, dir, s_in, modo, d, q,
    input  armed, err, err_sticky, chk_cnt, err_cnt, first_exp, first_got
  );

  modport slave (
    input  enb, dir, s_in, modo, d, q,
    output armed, err, err_sticky, chk_cnt, err_cnt, first_exp, first_got
  );
endinterface

// File: rtl/shift_reg_32_checker.sv
// rtl/shift_reg_32_checker.sv - cycle-accurate monitor for the universal shift register
//   clk_i  : clock shared with the register, rising edge
//   rst_i  : asynchronous active-high reset
//   mon_if : slave side of shift_reg_32_checker_if (taps in, status out)
module shift_reg_32_checker #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  shift_reg_32_checker_if.slave  mon_if
);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;
  logic             pend_q;
  logic             err_q;
  logic             sticky_q;
  logic [CNT_W-1:0] chk_cnt_q;
  logic [CNT_W-1:0] chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_got_q;
  logic             mismatch;

  // Model next value and saturating counter increments.
  always_comb begin
    exp_d = exp_q;
    if (mon_if.enb) begin
      case (mon_if.modo)
        2'b00:   exp_d = mon_if.dir ? {mon_if.s_in, exp_q[WIDTH-1:1]}
                                    : {exp_q[WIDTH-2:0], mon_if.s_in};
        2'b01:   exp_d = mon_if.dir ? {exp_q[0], exp_q[WIDTH-1:1]}
                                    : {exp_q[WIDTH-2:0], exp_q[WIDTH-1]};
        2'b10:   exp_d = mon_if.d;
        default: exp_d = exp_q;
      endcase
    end
    chk_cnt_d = (&chk_cnt_q) ? chk_cnt_q : chk_cnt_q + CNT_W'(1);
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    // Case inequality so an X/Z on q is reported rather than masked.
    mismatch  = (mon_if.q !== exp_q);
  end

  // q seen at this edge is the register's result of the previous edge, so it
  // is compared against exp_q before exp_q takes this edge's update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_UNARMED;
      exp_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_UNARMED: begin
          // Only a parallel load gives the model a known value.
          if (mon_if.enb && mon_if.modo == 2'b10) begin
            exp_q   <= mon_if.d;
            pend_q  <= 1'b1;
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          exp_q  <= exp_d;
          pend_q <= 1'b1;
          if (pend_q) begin
            chk_cnt_q <= chk_cnt_d;
            if (mismatch) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
              sticky_q  <= 1'b1;
              if (!sticky_q) begin
                first_exp_q <= exp_q;
                first_got_q <= mon_if.q;
              end
              if (STOP_ON_ERR != 0) begin
                state_q <= ST_HALTED;
              end
            end
          end
        end
        default: begin
          // Halted: everything frozen until reset.
          pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon_if.armed      = (state_q != ST_UNARMED);
  assign mon_if.err        = err_q;
  assign mon_if.err_sticky = sticky_q;
  assign mon_if.chk_cnt    = chk_cnt_q;
  assign mon_if.err_cnt    = err_cnt_q;
  assign mon_if.first_exp  = first_exp_q;
  assign mon_if.first_got  = first_got_q;

endmodule

// File: tb/tb_shift_reg_32_checker.sv
// tb/tb_shift_reg_32_checker.sv - randomized self-checking bench for shift_reg_32_checker
module tb_shift_reg_32_checker;

  logic        clk;
  logic        rst;
  logic        enb;
  logic        dir;
  logic        s_in;
  logic [1:0]  modo;
  logic [31:0] d;
  logic [31:0] q;

  int n_total = 0;
  int n_bad   = 0;

  // Instance 0: defaults, 1: stop on first error, 2: 2-bit counters.
  shift_reg_32_checker_if #(.WIDTH(32), .CNT_W(16)) if0 ();
  shift_reg_32_checker_if #(.WIDTH(32), .CNT_W(16)) if1 ();
  shift_reg_32_checker_if #(.WIDTH(32), .CNT_W(2))  if2 ();

  shift_reg_32_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_ERR(0)) u_chk0 (.clk_i(clk), .rst_i(rst), .mon_if(if0));
  shift_reg_32_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_ERR(1)) u_chk1 (.clk_i(clk), .rst_i(rst), .mon_if(if1));
  shift_reg_32_checker #(.WIDTH(32), .CNT_W(2),  .STOP_ON_ERR(0)) u_chk2 (.clk_i(clk), .rst_i(rst), .mon_if(if2));

  assign if0.enb = enb;  assign if0.dir = dir;  assign if0.s_in = s_in;
  assign if0.modo = modo; assign if0.d = d;     assign if0.q = q;
  assign if1.enb = enb;  assign if1.dir = dir;  assign if1.s_in = s_in;
  assign if1.modo = modo; assign if1.d = d;     assign if1.q = q;
  assign if2.enb = enb;  assign if2.dir = dir;  assign if2.s_in = s_in;
  assign if2.modo = modo; assign if2.d = d;     assign if2.q = q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden register value and expected checker status per instance.
  logic [31:0] ref_reg;
  bit          m_armed  [3];
  bit          m_halt   [3];
  bit          m_pend   [3];
  bit          m_err    [3];
  bit          m_sticky [3];
  int          m_chk    [3];
  int          m_errc   [3];
  logic [31:0] m_fexp   [3];
  logic [31:0] m_fgot   [3];

  function automatic int cmax(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_armed[k] = 0; m_halt[k] = 0; m_pend[k] = 0; m_err[k] = 0; m_sticky[k] = 0;
      m_chk[k] = 0; m_errc[k] = 0; m_fexp[k] = '0; m_fgot[k] = '0;
    end
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic a, input logic e, input logic s,
                            input logic [15:0] c, input logic [15:0] ec,
                            input logic [31:0] fe, input logic [31:0] fg);
    check_eq($sformatf("i%0d.armed", k),     64'(a),  64'(m_armed[k]));
    check_eq($sformatf("i%0d.err", k),       64'(e),  64'(m_err[k]));
    check_eq($sformatf("i%0d.sticky", k),    64'(s),  64'(m_sticky[k]));
    check_eq($sformatf("i%0d.chk_cnt", k),   64'(c),  64'(m_chk[k]));
    check_eq($sformatf("i%0d.err_cnt", k),   64'(ec), 64'(m_errc[k]));
    check_eq($sformatf("i%0d.first_exp", k), 64'(fe), 64'(m_fexp[k]));
    check_eq($sformatf("i%0d.first_got", k), 64'(fg), 64'(m_fgot[k]));
  endtask

  task automatic check_all();
    check_inst(0, if0.armed, if0.err, if0.err_sticky, 16'(if0.chk_cnt), 16'(if0.err_cnt), if0.first_exp, if0.first_got);
    check_inst(1, if1.armed, if1.err, if1.err_sticky, 16'(if1.chk_cnt), 16'(if1.err_cnt), if1.first_exp, if1.first_got);
    check_inst(2, if2.armed, if2.err, if2.err_sticky, 16'(if2.chk_cnt), 16'(if2.err_cnt), if2.first_exp, if2.first_got);
  endtask

  // One clock: drive stimulus at the falling edge, q = golden value with an
  // optional corruption (fm) or X, predict the checker, then check after the edge.
  task automatic step(input bit r, input bit e, input bit dr, input bit si, input bit [1:0] m,
                      input bit [31:0] dv, input bit [31:0] fm, input bit xq);
    bit bad_q;
    @(negedge clk);
    rst = r; enb = e; dir = dr; s_in = si; modo = m; d = dv;
    if (xq) q = 'x;
    else    q = ref_reg ^ fm;
    bad_q = xq || (fm != 0);
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_err[k] = 0;
        if (m_pend[k]) begin
          if (m_chk[k] < cmax(k)) m_chk[k]++;
          if (bad_q) begin
            m_err[k] = 1;
            if (m_errc[k] < cmax(k)) m_errc[k]++;
            if (!m_sticky[k]) begin
              m_fexp[k] = ref_reg;
              m_fgot[k] = q;
              m_sticky[k] = 1;
            end
            if (k == 1) m_halt[k] = 1;
          end
        end
        if (!m_armed[k] && e && m == 2'b10) m_armed[k] = 1;
        m_pend[k] = m_armed[k] && !m_halt[k];
      end
    end
    if (e) begin
      case (m)
        2'b00: ref_reg = dr ? ((ref_reg >> 1) | (32'(si) << 31)) : ((ref_reg << 1) | 32'(si));
        2'b01: ref_reg = dr ? ((ref_reg >> 1) | (ref_reg << 31)) : ((ref_reg << 1) | (ref_reg >> 31));
        2'b10: ref_reg = dv;
        default: ref_reg = ref_reg;
      endcase
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit [31:0] dv;
    rst = 1'b1; enb = 1'b0; dir = 1'b0; s_in = 1'b0; modo = 2'b11; d = '0; q = '0;
    ref_reg = '0;
    model_reset();
    #2;
    check_all();  // reset state before any clock edge
    step(1, 0, 0, 0, 2'b11, 0, 0, 0);

    // Shifts before any load: nothing is compared.
    for (int i = 0; i < 5; i++)
      step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 0, 0, 0);
    check_eq("a.chk_unarmed", 64'(if0.chk_cnt), 64'd0);

    // 31 back-to-back loads with a correct register.
    for (int i = 0; i < 31; i++) begin
      dv = (i == 0) ? 32'h2 : (i == 1) ? 32'hF : (i == 2) ? 32'h3 :
           (i == 30) ? 32'h5555_5555 : $urandom;
      step(0, 1, 0, 0, 2'b10, dv, 0, 0);
    end
    check_eq("b.chk30", 64'(if0.chk_cnt), 64'd30);
    check_eq("b.armed", 64'(if0.armed), 64'd1);

    // Load then four left shifts of 1 -> 0x1F; register reports 0x1E.
    step(0, 1, 0, 0, 2'b10, 32'h8000_0001, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 2'b00, 0, 0, 0);
    step(0, 1, 0, 0, 2'b11, 0, 32'h1, 0);
    check_eq("c.err", 64'(if0.err), 64'd1);
    check_eq("c.err_cnt", 64'(if0.err_cnt), 64'd1);
    check_eq("c.first_exp", 64'(if0.first_exp), 64'h1F);
    check_eq("c.first_got", 64'(if0.first_got), 64'h1E);
    step(0, 1, 0, 0, 2'b11, 0, 32'h4, 0);  // second consecutive mismatch
    check_eq("c.halt_err_cnt", 64'(if1.err_cnt), 64'd1);
    step(0, 1, 0, 0, 2'b11, 0, 0, 0);
    step(0, 1, 0, 1, 2'b00, 0, 0, 0);
    check_eq("c.halt_chk", 64'(if1.chk_cnt), 64'd36);
    check_eq("c.halt_armed", 64'(if1.armed), 64'd1);
    check_eq("c.sat_chk", 64'(if2.chk_cnt), 64'd3);

    // Asynchronous reset in the middle of a low clock phase.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1, 0, 0, 0, 2'b11, 0, 0, 0);

    // Load 1, rotate right once, then three disabled edges.
    step(0, 1, 0, 0, 2'b10, 32'h1, 0, 0);
    step(0, 1, 1, 0, 2'b01, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 0, 0);
    check_eq("d.chk4", 64'(if0.chk_cnt), 64'd4);
    check_eq("d.no_err", 64'(if0.err_cnt), 64'd0);
    step(0, 1, 0, 0, 2'b11, 0, 0, 1);  // unknown q
    check_eq("d.x_err", 64'(if0.err), 64'd1);

    // Random traffic with sparse corruptions and resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom, ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
